// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract engine: steps one gate-level full adder LSB-first over
// WIDTH cycles, carry held in a flop, registered result behind valid/ready.

module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic axb, c1, c2;
  xor g_x1 (axb, a, b);
  xor g_x2 (sum, axb, cin);
  and g_a1 (c1, a, b);
  and g_a2 (c2, axb, cin);
  or  g_o1 (cout, c1, c2);
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  structuralFullAdder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (c),
    .sum (fa_s),
    .cout(fa_co)
  );

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_bit)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= sub ? ~b : b;
      c    <= sub;
      cnt  <= '0;
    end else if (state == RUN) begin
      r_sh <= {fa_s, r_sh[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c    <= fa_co;
      cnt  <= cnt + 1'b1;
      // On the MSB step, c is the carry into the MSB, so overflow is c ^ carry-out.
      if (last_bit) begin
        sum      <= {fa_s, r_sh[WIDTH-1:1]};
        carryout <= fa_co;
        overflow <= c ^ fa_co;
      end
    end
  end
endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Bit-serial add/subtract engine built around a single instance of the team's `structuralFullAdder`. It accepts two WIDTH-bit operands through a valid/ready handshake and steps the one full adder LSB-first over WIDTH clock cycles, holding the carry in a flop between bits. It returns a registered result with carry-out and signed overflow through a second valid/ready handshake. It is the sequencing layer that turns the gate-level full adder into a usable multi-bit arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A−B; sampled with operands
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, registered
- carryout  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

## Operation
- One clock; reset is asynchronous and active-low.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, load shift registers a_sh←a, b_sh←(sub ? ~b : b), carry flop c←sub, bit counter←0, then go to RUN.
  - RUN: the full adder sees (a_sh[0], b_sh[0], c). Each edge:
    - the sum bit shifts into the MSB of the result shift register;
    - a_sh and b_sh shift right;
    - c←carryout;
    - count++.
  - On the edge where count==WIDTH−1, capture cin_msb←c (carry into the MSB) and go to DONE.
  - DONE: out_valid=1; sum, carryout and overflow are stable. On out_valid&&out_ready go to IDLE.
- Outputs:
  - carryout = final c.
  - overflow = cin_msb XOR carryout.
- sum/carryout/overflow are updated only on the edge entering DONE. They hold their value through IDLE until the next result completes, so the consumer never sees partial bits.
- in_valid outside IDLE is ignored (in_ready=0). Operands may change freely after acceptance.
- in_ready is low during the cycle out_ready is taken, so there is no accept in the same cycle. The next accept is possible one cycle later.
- Width rules: arithmetic is modulo 2^WIDTH. The counter is ⌈log2 WIDTH⌉+1 bits and cannot wrap within an operation.
- The full adder must not be replaced with behavioural `+`; the block exists to sequence the structural cell.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carryout=0, overflow=0, c=0, count=0.
- Reset mid-RUN or mid-DONE aborts the operation; no out_valid follows. The first accept after reset deasserts behaves normally.
- Latency:
  - accept on edge E0;
  - bits 0..WIDTH−1 are computed on edges E1..E_WIDTH;
  - out_valid is high after E_WIDTH.
- Throughput with out_ready held high: one result every WIDTH+2 cycles.
- Backpressure: with out_ready low, DONE holds indefinitely and outputs stay constant.
- Full-adder path is XOR→AND→OR at 50 units each, i.e. 150 units. The clock period must be ≥ 200 units; the bench uses 400.
- All outputs are driven from flops; there are no combinational input-to-output paths.

## Test plan
- WIDTH=8, add 100+27 → after 8 cycles out_valid: sum=127, carryout=0, overflow=0.
- Add 200+100 → sum=44, carryout=1, overflow=0. Then 127+1 → sum=128, carryout=0, overflow=1.
- Sub 5−7 → sum=254, carryout=0, overflow=0. Sub 0x80−1 → sum=0x7F, carryout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulsing in_valid with new operands. Required: sum held, in_ready=0, nothing accepted. Release → IDLE next cycle, then the pending request is accepted.
- Reset: assert rst_n=0 at bit 4 of a RUN. Required: outputs zero immediately, out_valid never rises. After release, 3+4 → sum=7.
- Back-to-back: 10 random add/sub operations with out_ready=1, checked against a reference model. Required: results match and the in_ready period is exactly WIDTH+2 cycles.
